multicycle_ctrl: RTL and testbench

Control FSM for the multicycle MIPS core. It steps every instruction through IF/ID/EXE/MEM/WB and drives the per-state control strobes for the datapath. It issues exactly one PCWre pulse per retired instruction to the program-counter register and holds the PC frozen after `halt`. It sits between the instruction register (opcode field) and ALU zero flag on one side, and the PC, register file, ALU muxes and data memory on the other.

---
 rtl/multicycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle MIPS core.
// Steps each instruction through IF/ID/EXE/MEM/WB and decodes the datapath
// strobes from the registered state plus the opcode and ALU zero flag.
// Each instruction raises PCWre for exactly one cycle, in the state where it
// retires. PCWre never rises once the FSM reaches HALT.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic [3:0]       state,
  output logic             PCWre,
  output logic             IRWre,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             RegWre,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instr_count;

  logic w_is_rtype;
  logic w_is_itype;
  logic w_is_alu;
  logic w_is_ls;
  logic w_is_br;
  logic w_is_jmp;
  logic w_is_halt;
  logic w_is_nop;
  logic w_br_taken;

  // ALU operation selected by the arithmetic/logic opcodes
  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:          alu_op_of = 3'b001;
      OP_SLL:          alu_op_of = 3'b010;
      OP_OR, OP_ORI:   alu_op_of = 3'b011;
      OP_AND:          alu_op_of = 3'b100;
      OP_SLT, OP_SLTI: alu_op_of = 3'b101;
      default:         alu_op_of = 3'b000;
    endcase
  endfunction

  // Opcode class decode; anything unrecognised falls through to nop
  always_comb begin
    w_is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                 (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_SLT);
    w_is_itype = (opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_SLTI);
    w_is_alu   = w_is_rtype || w_is_itype;
    w_is_ls    = (opcode == OP_SW) || (opcode == OP_LW);
    w_is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    w_is_jmp   = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL);
    w_is_halt  = (opcode == OP_HALT);
    w_is_nop   = !(w_is_alu || w_is_ls || w_is_br || w_is_jmp || w_is_halt);
    w_br_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IF;
    else     r_state <= w_next_state;
  end

  // Retired-instruction counter, advanced on the same edge as the PC load
  always_ff @(posedge CLK) begin
    if (RST)        r_instr_count <= '0;
    else if (PCWre) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_next_state = S_IF;
    PCWre        = 1'b0;
    IRWre        = 1'b0;
    PCSrc        = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 1'b0;
    ALUOp        = 3'b000;
    RegDst       = 2'b00;
    RegWre       = 1'b0;
    WrRegDSrc    = 1'b0;
    DBDataSrc    = 1'b0;
    mRD          = 1'b0;
    mWR          = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IF: begin
        IRWre        = 1'b1;
        w_next_state = S_ID;
      end
      S_ID: begin
        if (w_is_jmp || w_is_nop) begin
          // Jumps and nops retire straight out of decode
          PCWre        = 1'b1;
          w_next_state = S_IF;
          if ((opcode == OP_J) || (opcode == OP_JAL)) PCSrc = 2'b11;
          else if (opcode == OP_JR)                   PCSrc = 2'b10;
          if (opcode == OP_JAL) begin
            RegWre    = 1'b1;
            RegDst    = 2'b10;
            WrRegDSrc = 1'b0;
          end
        end else if (w_is_br) begin
          w_next_state = S_EXE_BR;
        end else if (w_is_ls) begin
          w_next_state = S_EXE_LS;
        end else if (w_is_halt) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_EXE_AL;
        end
      end
      S_EXE_AL: begin
        ALUOp        = alu_op_of(opcode);
        ALUSrcA      = (opcode == OP_SLL);
        ALUSrcB      = w_is_itype;
        w_next_state = S_WB_AL;
      end
      S_WB_AL: begin
        ALUOp        = alu_op_of(opcode);
        ALUSrcA      = (opcode == OP_SLL);
        ALUSrcB      = w_is_itype;
        RegWre       = 1'b1;
        RegDst       = w_is_rtype ? 2'b01 : 2'b00;
        WrRegDSrc    = 1'b1;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_EXE_BR: begin
        ALUOp        = 3'b001;
        PCSrc        = w_br_taken ? 2'b01 : 2'b00;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_EXE_LS: begin
        ALUSrcB      = 1'b1;
        w_next_state = S_MEM;
      end
      S_MEM: begin
        ALUSrcB = 1'b1;
        if (opcode == OP_SW) begin
          mWR          = 1'b1;
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end else begin
          mRD          = 1'b1;
          w_next_state = S_WB_LD;
        end
      end
      S_WB_LD: begin
        ALUSrcB      = 1'b1;
        RegWre       = 1'b1;
        RegDst       = 2'b00;
        DBDataSrc    = 1'b1;
        WrRegDSrc    = 1'b1;
        PCWre        = 1'b1;
        w_next_state = S_IF;
      end
      S_HALT: begin
        halted       = 1'b1;
        w_next_state = S_HALT;
      end
      default: w_next_state = S_IF;
    endcase
  end

  assign ExtSel      = (opcode != OP_ORI);
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks strobes against hand-derived values.
module tb_multicycle_ctrl;

  logic        CLK;
  logic        RST;
  logic [5:0]  opcode;
  logic        zero;
  logic [3:0]  state;
  logic        PCWre;
  logic        IRWre;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic        ExtSel;
  logic [1:0]  RegDst;
  logic        RegWre;
  logic        WrRegDSrc;
  logic        DBDataSrc;
  logic        mRD;
  logic        mWR;
  logic        halted;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
    .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .halted(halted), .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST    = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", instr_count, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_irwre", 32'(IRWre), 1);
    chk("rst_pcwre", 32'(PCWre), 0);
    RST = 1'b0;

    // add: IF -> ID -> EXE_AL -> WB_AL -> IF
    step(); chk("add_id", 32'(state), 1); chk("add_id_pcwre", 32'(PCWre), 0);
    step(); chk("add_exe", 32'(state), 6); chk("add_exe_pcwre", 32'(PCWre), 0);
    chk("add_exe_aluop", 32'(ALUOp), 0); chk("add_exe_srcb", 32'(ALUSrcB), 0);
    step(); chk("add_wb", 32'(state), 7); chk("add_wb_pcwre", 32'(PCWre), 1);
    chk("add_wb_regwre", 32'(RegWre), 1); chk("add_wb_regdst", 32'(RegDst), 1);
    chk("add_wb_wrsrc", 32'(WrRegDSrc), 1);
    step(); chk("add_if", 32'(state), 0); chk("add_count", instr_count, 1);

    // beq taken
    opcode = 6'b110100; zero = 1'b1;
    step(); chk("beq1_id", 32'(state), 1);
    step(); chk("beq1_br", 32'(state), 5); chk("beq1_pcsrc", 32'(PCSrc), 1);
    chk("beq1_pcwre", 32'(PCWre), 1); chk("beq1_aluop", 32'(ALUOp), 1);
    step(); chk("beq1_if", 32'(state), 0); chk("beq1_count", instr_count, 2);

    // beq not taken
    zero = 1'b0;
    step(); step(); chk("beq0_pcsrc", 32'(PCSrc), 0); chk("beq0_pcwre", 32'(PCWre), 1);
    step(); chk("beq0_if", 32'(state), 0);

    // bne taken (zero=0)
    opcode = 6'b110101;
    step(); step(); chk("bne_br", 32'(state), 5); chk("bne_pcsrc", 32'(PCSrc), 1);
    zero = 1'b1; #1; chk("bne_zero_comb", 32'(PCSrc), 0); zero = 1'b0;
    step(); chk("bne_count", instr_count, 4);

    // lw then sw back to back: 5 + 4 cycles
    opcode = 6'b110001;
    step(); chk("lw_id", 32'(state), 1);
    step(); chk("lw_exe", 32'(state), 2); chk("lw_exe_srcb", 32'(ALUSrcB), 1);
    chk("lw_exe_mrd", 32'(mRD), 0);
    step(); chk("lw_mem", 32'(state), 3); chk("lw_mem_mrd", 32'(mRD), 1);
    chk("lw_mem_mwr", 32'(mWR), 0); chk("lw_mem_pcwre", 32'(PCWre), 0);
    step(); chk("lw_wb", 32'(state), 4); chk("lw_wb_dbsrc", 32'(DBDataSrc), 1);
    chk("lw_wb_regwre", 32'(RegWre), 1); chk("lw_wb_mrd", 32'(mRD), 0);
    chk("lw_wb_pcwre", 32'(PCWre), 1);
    step(); chk("lw_if", 32'(state), 0);
    opcode = 6'b110000;
    step(); step(); chk("sw_exe", 32'(state), 2);
    step(); chk("sw_mem", 32'(state), 3); chk("sw_mem_mwr", 32'(mWR), 1);
    chk("sw_mem_mrd", 32'(mRD), 0); chk("sw_mem_pcwre", 32'(PCWre), 1);
    step(); chk("sw_if", 32'(state), 0); chk("lwsw_count", instr_count, 6);

    // jal
    opcode = 6'b111010;
    step(); chk("jal_id", 32'(state), 1); chk("jal_pcsrc", 32'(PCSrc), 3);
    chk("jal_regwre", 32'(RegWre), 1); chk("jal_regdst", 32'(RegDst), 2);
    chk("jal_wrsrc", 32'(WrRegDSrc), 0); chk("jal_pcwre", 32'(PCWre), 1);
    step(); chk("jal_if", 32'(state), 0);

    // jr
    opcode = 6'b111001;
    step(); chk("jr_pcsrc", 32'(PCSrc), 2); chk("jr_regwre", 32'(RegWre), 0);
    step(); chk("jr_if", 32'(state), 0);

    // undefined opcode -> nop
    opcode = 6'b101010;
    step(); chk("nop_pcsrc", 32'(PCSrc), 0); chk("nop_pcwre", 32'(PCWre), 1);
    chk("nop_regwre", 32'(RegWre), 0);
    step(); chk("nop_if", 32'(state), 0); chk("nop_count", instr_count, 9);

    // ori: zero-extend, immediate source, rt destination
    opcode = 6'b010010;
    chk("ori_extsel", 32'(ExtSel), 0);
    step(); step(); chk("ori_aluop", 32'(ALUOp), 3); chk("ori_srcb", 32'(ALUSrcB), 1);
    step(); chk("ori_regdst", 32'(RegDst), 0); chk("ori_pcwre", 32'(PCWre), 1);
    step();

    // sll: shamt source
    opcode = 6'b011000;
    chk("sll_extsel", 32'(ExtSel), 1);
    step(); step(); chk("sll_srca", 32'(ALUSrcA), 1); chk("sll_aluop", 32'(ALUOp), 2);
    step(); step(); chk("sll_count", instr_count, 11);

    // halt: sticks, never loads the PC, not counted
    opcode = 6'b111111;
    step(); chk("halt_id_pcwre", 32'(PCWre), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_state", 32'(state), 8);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_pcwre", 32'(PCWre), 0);
    end
    chk("halt_count", instr_count, 11);
    RST = 1'b1;
    step(); chk("halt_rst_state", 32'(state), 0); chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_count", instr_count, 0);
    RST = 1'b0;

    // reset during lw's MEM skips WB_LD
    opcode = 6'b110001;
    step(); step(); step(); chk("lwr_mem", 32'(state), 3);
    RST = 1'b1;
    step(); chk("lwr_state", 32'(state), 0); chk("lwr_regwre", 32'(RegWre), 0);
    chk("lwr_pcwre", 32'(PCWre), 0); chk("lwr_irwre", 32'(IRWre), 1);
    RST = 1'b0;
    step(); chk("lwr_id", 32'(state), 1); chk("lwr_id_regwre", 32'(RegWre), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
